// File: rtl/exu_wb_arb.sv
// exu_wb_arb: EXU writeback arbiter. Buffers ALU/MUL/DIV/LSU results in small
// per-source FIFOs and grants one per cycle (LSU > DIV > MUL > ALU) to a single
// registered regfile write port that also feeds IDU1 forwarding.
// Optional feature: define EXU_WB_TAG_EN to carry an instr_tag with each result.
module exu_wb_arb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
`ifdef EXU_WB_TAG_EN
  , parameter int unsigned TAG_WIDTH = 8
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd_addr,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            mul_wb_valid,
  input  logic [4:0]      mul_wb_rd_addr,
  input  logic [XLEN-1:0] mul_wb_data,
  output logic            mul_wb_ready,
  input  logic            div_wb_valid,
  input  logic [4:0]      div_wb_rd_addr,
  input  logic [XLEN-1:0] div_wb_data,
  output logic            div_wb_ready,
  input  logic            lsu_wb_valid,
  input  logic [4:0]      lsu_wb_rd_addr,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,
  output logic [XLEN-1:0] exu_wb_data,
  output logic [4:0]      exu_wb_rd_addr,
  output logic            exu_wb_rd_wr_en,
  output logic            exu_wb_busy
`ifdef EXU_WB_TAG_EN
  , input  logic [TAG_WIDTH-1:0] alu_wb_instr_tag,
  input  logic [TAG_WIDTH-1:0]   mul_wb_instr_tag,
  input  logic [TAG_WIDTH-1:0]   div_wb_instr_tag,
  input  logic [TAG_WIDTH-1:0]   lsu_wb_instr_tag,
  output logic [TAG_WIDTH-1:0]   exu_wb_instr_tag
`endif
);

  localparam int unsigned NumSrc = 4;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
`ifdef EXU_WB_TAG_EN
  localparam int unsigned EntW   = TAG_WIDTH + 5 + XLEN;
`else
  localparam int unsigned EntW   = 5 + XLEN;
`endif

  // Source index: 0=ALU, 1=MUL, 2=DIV, 3=LSU (higher index wins).
  logic [NumSrc-1:0] in_valid, ready, has_head, cand_valid, grant, push, pop;
  logic [EntW-1:0]   in_ent   [NumSrc];
  logic [EntW-1:0]   cand_ent [NumSrc];
  logic [EntW-1:0]   win_ent;
  logic [4:0]        win_rd;
  logic [XLEN-1:0]   win_data;

  logic [EntW-1:0]   mem_q  [NumSrc][DEPTH];
  logic [PtrW-1:0]   rptr_q [NumSrc];
  logic [PtrW-1:0]   wptr_q [NumSrc];
  logic [CntW-1:0]   cnt_q  [NumSrc];

  assign in_valid = {lsu_wb_valid, div_wb_valid, mul_wb_valid, alu_wb_valid};
`ifdef EXU_WB_TAG_EN
  assign in_ent[0] = {alu_wb_instr_tag, alu_wb_rd_addr, alu_wb_data};
  assign in_ent[1] = {mul_wb_instr_tag, mul_wb_rd_addr, mul_wb_data};
  assign in_ent[2] = {div_wb_instr_tag, div_wb_rd_addr, div_wb_data};
  assign in_ent[3] = {lsu_wb_instr_tag, lsu_wb_rd_addr, lsu_wb_data};
`else
  assign in_ent[0] = {alu_wb_rd_addr, alu_wb_data};
  assign in_ent[1] = {mul_wb_rd_addr, mul_wb_data};
  assign in_ent[2] = {div_wb_rd_addr, div_wb_data};
  assign in_ent[3] = {lsu_wb_rd_addr, lsu_wb_data};
`endif

  // Per-source FIFO status and candidate: queued head first, else bypass of the input.
  always_comb begin
    ready      = '0;
    has_head   = '0;
    cand_valid = '0;
    for (int s = 0; s < NumSrc; s++) begin
      ready[s]      = (cnt_q[s] != CntW'(DEPTH));
      has_head[s]   = (cnt_q[s] != '0);
      cand_valid[s] = has_head[s] | in_valid[s];
      cand_ent[s]   = has_head[s] ? mem_q[s][rptr_q[s]] : in_ent[s];
    end
  end

  // Fixed-priority grant plus FIFO push/pop decisions.
  always_comb begin
    grant   = '0;
    win_ent = cand_ent[0];
    if (cand_valid[3]) begin
      grant[3] = 1'b1;
      win_ent  = cand_ent[3];
    end else if (cand_valid[2]) begin
      grant[2] = 1'b1;
      win_ent  = cand_ent[2];
    end else if (cand_valid[1]) begin
      grant[1] = 1'b1;
      win_ent  = cand_ent[1];
    end else if (cand_valid[0]) begin
      grant[0] = 1'b1;
    end
    push = '0;
    pop  = '0;
    for (int s = 0; s < NumSrc; s++) begin
      pop[s]  = grant[s] & has_head[s];
      // A granted bypass goes straight out and is never stored.
      push[s] = in_valid[s] & ready[s] & ~(grant[s] & ~has_head[s]);
    end
  end

  assign win_data = win_ent[XLEN-1:0];
  assign win_rd   = win_ent[XLEN+4:XLEN];

  // FIFO storage write; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NumSrc; s++) begin
      if (push[s]) mem_q[s][wptr_q[s]] <= in_ent[s];
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NumSrc; s++) begin
        rptr_q[s] <= '0;
        wptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NumSrc; s++) begin
        if (push[s]) wptr_q[s] <= wptr_q[s] + PtrW'(1);
        if (pop[s])  rptr_q[s] <= rptr_q[s] + PtrW'(1);
        cnt_q[s] <= cnt_q[s] + CntW'(push[s]) - CntW'(pop[s]);
      end
    end
  end

  // Registered write port; data/addr hold when idle, x0 writes never enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exu_wb_data      <= '0;
      exu_wb_rd_addr   <= '0;
      exu_wb_rd_wr_en  <= 1'b0;
`ifdef EXU_WB_TAG_EN
      exu_wb_instr_tag <= '0;
`endif
    end else if (|grant) begin
      exu_wb_data      <= win_data;
      exu_wb_rd_addr   <= win_rd;
      exu_wb_rd_wr_en  <= (win_rd != 5'd0);
`ifdef EXU_WB_TAG_EN
      exu_wb_instr_tag <= win_ent[EntW-1 -: TAG_WIDTH];
`endif
    end else begin
      exu_wb_rd_wr_en  <= 1'b0;
    end
  end

  assign exu_wb_busy  = |has_head;
  assign alu_wb_ready = ready[0];
  assign mul_wb_ready = ready[1];
  assign div_wb_ready = ready[2];
  assign lsu_wb_ready = ready[3];

endmodule
